// File: rtl/char_text_buffer.sv
// Character-cell text buffer: byte stream in, ROWS x COLS grid of codes out to the renderer.
// Display lookup is registered (1 cycle); writes stall only during CLEAR and SCROLL.
module char_text_buffer #(
    parameter int         COLS  = 30,
    parameter int         ROWS  = 8,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       clear,
    output logic [4:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       busy
);
    localparam int         CELLS      = COLS * ROWS;
    localparam logic [7:0] COLS_A     = 8'(COLS);
    localparam logic [7:0] LAST_A     = 8'(CELLS - 1);
    localparam logic [7:0] LAST_ROW_A = 8'((ROWS - 1) * COLS);
    localparam logic [4:0] X_LAST     = 5'(COLS - 1);
    localparam logic [2:0] Y_LAST     = 3'(ROWS - 1);
    localparam logic [5:0] COLS_CMP   = 6'(COLS);
    localparam logic [3:0] ROWS_CMP   = 4'(ROWS);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_SCROLL_RD,
        S_SCROLL_WR,
        S_SCROLL_BLANK
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] addr, addr_nxt;
    logic [4:0] cx_nxt;
    logic [2:0] cy_nxt;
    logic [7:0] scroll_dat;

    logic [7:0] mem [CELLS];
    logic       mem_we;
    logic [7:0] mem_wa;
    logic [7:0] mem_wd;

    logic [7:0] cur_addr;
    logic [7:0] disp_a;
    logic       disp_in;
    logic       is_print;
    logic       is_nl;
    logic       is_bs;

    assign cur_addr = {5'd0, cursor_y} * COLS_A + {3'd0, cursor_x};
    assign disp_a   = {5'd0, char_xy[7:5]} * COLS_A + {3'd0, char_xy[4:0]};
    assign disp_in  = ({1'b0, char_xy[4:0]} < COLS_CMP) && ({1'b0, char_xy[7:5]} < ROWS_CMP);

    assign is_print = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
    assign is_nl    = (wr_data == 8'h0A) || (wr_data == 8'h0D);
    assign is_bs    = (wr_data == 8'h08);

    assign wr_ready = (state == S_IDLE) && !clear;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= S_CLEAR;
            addr     <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            cursor_x <= cx_nxt;
            cursor_y <= cy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cx_nxt    = cursor_x;
        cy_nxt    = cursor_y;
        mem_we    = 1'b0;
        mem_wa    = addr;
        mem_wd    = BLANK;
        if (clear) begin
            state_nxt = S_CLEAR;
            addr_nxt  = '0;
            cx_nxt    = '0;
            cy_nxt    = '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    mem_we = 1'b1;
                    cx_nxt = '0;
                    cy_nxt = '0;
                    if (addr == LAST_A) begin
                        state_nxt = S_IDLE;
                    end else begin
                        addr_nxt = addr + 8'd1;
                    end
                end
                S_IDLE: begin
                    if (wr_valid) begin
                        if (is_print) begin
                            mem_we = 1'b1;
                            mem_wa = cur_addr;
                            mem_wd = wr_data;
                            if (cursor_x == X_LAST) begin
                                cx_nxt = '0;
                                if (cursor_y == Y_LAST) begin
                                    state_nxt = S_SCROLL_RD;
                                    addr_nxt  = COLS_A;
                                end else begin
                                    cy_nxt = cursor_y + 3'd1;
                                end
                            end else begin
                                cx_nxt = cursor_x + 5'd1;
                            end
                        end else if (is_nl) begin
                            cx_nxt = '0;
                            if (cursor_y == Y_LAST) begin
                                state_nxt = S_SCROLL_RD;
                                addr_nxt  = COLS_A;
                            end else begin
                                cy_nxt = cursor_y + 3'd1;
                            end
                        end else if (is_bs) begin
                            // Linear addressing makes the previous cell cur_addr-1 even across rows.
                            mem_wa = cur_addr - 8'd1;
                            if (cursor_x != 5'd0) begin
                                mem_we = 1'b1;
                                cx_nxt = cursor_x - 5'd1;
                            end else if (cursor_y != 3'd0) begin
                                mem_we = 1'b1;
                                cx_nxt = X_LAST;
                                cy_nxt = cursor_y - 3'd1;
                            end
                        end
                    end
                end
                S_SCROLL_RD: begin
                    state_nxt = S_SCROLL_WR;
                end
                S_SCROLL_WR: begin
                    mem_we = 1'b1;
                    mem_wa = addr - COLS_A;
                    mem_wd = scroll_dat;
                    if (addr == LAST_A) begin
                        state_nxt = S_SCROLL_BLANK;
                        addr_nxt  = LAST_ROW_A;
                    end else begin
                        state_nxt = S_SCROLL_RD;
                        addr_nxt  = addr + 8'd1;
                    end
                end
                S_SCROLL_BLANK: begin
                    mem_we = 1'b1;
                    if (addr == LAST_A) begin
                        state_nxt = S_IDLE;
                    end else begin
                        addr_nxt = addr + 8'd1;
                    end
                end
                default: begin
                    state_nxt = S_CLEAR;
                    addr_nxt  = '0;
                end
            endcase
        end
    end

    // Grid storage is left unreset; CLEAR after reset initialises it.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        if (state == S_SCROLL_RD) begin
            scroll_dat <= mem[addr];
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            char_code <= '0;
        end else if (disp_in) begin
            char_code <= mem[disp_a][6:0];
        end else begin
            char_code <= BLANK[6:0];
        end
    end
endmodule

// File: tb/tb_char_text_buffer.sv
// Randomised bench for char_text_buffer against a grid-level reference model.
module tb_char_text_buffer;
    localparam int         COLS = 30;
    localparam int         ROWS = 8;
    localparam logic [7:0] BL   = 8'h20;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_xy = 8'd0;
    logic [6:0] char_code;
    logic [7:0] wr_data = 8'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       clear = 1'b0;
    logic [4:0] cursor_x;
    logic [2:0] cursor_y;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] mg [ROWS][COLS];
    int mx;
    int my;

    char_text_buffer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BL)) dut (
        .pclk     (pclk),
        .rst      (rst),
        .char_xy  (char_xy),
        .char_code(char_code),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .clear    (clear),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;

    // Reference model: a 2-D grid plus cursor, updated per accepted byte.
    task automatic model_blank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mg[r][c] = BL;
        mx = 0;
        my = 0;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                mg[r][c] = mg[r + 1][c];
        for (int c = 0; c < COLS; c++)
            mg[ROWS - 1][c] = BL;
    endtask

    task automatic model_put(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            mg[my][mx] = b;
            mx = mx + 1;
            if (mx == COLS) begin
                mx = 0;
                if (my == ROWS - 1) model_scroll();
                else my = my + 1;
            end
        end else if (b == 8'h0A || b == 8'h0D) begin
            mx = 0;
            if (my == ROWS - 1) model_scroll();
            else my = my + 1;
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                mg[my][mx] = BL;
            end else if (my > 0) begin
                my = my - 1;
                mx = COLS - 1;
                mg[my][mx] = BL;
            end
        end
    endtask

    // Offers one byte at a negedge; returns at the negedge after acceptance with wr_valid still high.
    task automatic drive_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!wr_ready && n < 2000) begin
            wr_valid = 1'b0;
            @(negedge pclk);
            n++;
        end
        if (!wr_ready) begin
            tests++;
            fails++;
            $display("FAIL drive_wait: wr_ready=%b after %0d cycles, required 1", wr_ready, n);
        end else begin
            wr_valid = 1'b1;
            wr_data  = b;
            model_put(b);
            @(negedge pclk);
        end
    endtask

    task automatic wait_busy(output int cnt);
        wr_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            @(negedge pclk);
        end
    endtask

    task automatic read_cell(input logic [7:0] xy, output logic [6:0] code);
        char_xy = xy;
        @(negedge pclk);
        code = char_code;
    endtask

    task automatic grid_diff(output int nbad, output int first);
        logic [6:0] code;
        nbad  = 0;
        first = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell({3'(r), 5'(c)}, code);
                if (code !== mg[r][c][6:0]) begin
                    if (nbad == 0) first = r * COLS + c;
                    nbad++;
                end
            end
    endtask

    task automatic test_reset();
        int cnt, nbad, first;
        logic [6:0] code;
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        tests++;
        if (char_code !== 7'd0 || wr_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_out: char_code=%h wr_ready=%b busy=%b, required 00 0 1", char_code, wr_ready, busy);
        end
        tests++;
        if (cursor_x !== 5'd0 || cursor_y !== 3'd0) begin
            fails++;
            $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", cursor_x, cursor_y);
        end
        rst = 1'b0;
        model_blank();
        wait_busy(cnt);
        tests++;
        if (cnt !== 240 || wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_clear_len: busy cycles=%0d wr_ready=%b, required 240 1", cnt, wr_ready);
        end
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0) begin
            fails++;
            $display("FAIL reset_grid: %0d bad cells, first at %0d, required all 20", nbad, first);
        end
        read_cell(8'h1F, code);
        tests++;
        if (code !== 7'h20) begin
            fails++;
            $display("FAIL reset_col31: char_code=%h, required 20", code);
        end
    endtask

    task automatic test_write();
        char_xy  = 8'h00;
        wr_valid = 1'b1;
        wr_data  = 8'h48;
        model_put(8'h48);
        @(negedge pclk);
        tests++;
        if (char_code !== 7'h20) begin
            fails++;
            $display("FAIL write_same_cycle_old: char_code=%h, required 20", char_code);
        end
        wr_data = 8'h49;
        model_put(8'h49);
        @(negedge pclk);
        wr_valid = 1'b0;
        tests++;
        if (char_code !== 7'h48) begin
            fails++;
            $display("FAIL write_cell0: char_code=%h, required 48", char_code);
        end
        char_xy = 8'h01;
        @(negedge pclk);
        tests++;
        if (char_code !== 7'h49) begin
            fails++;
            $display("FAIL write_cell1: char_code=%h, required 49", char_code);
        end
        tests++;
        if (cursor_x !== 5'd2 || cursor_y !== 3'd0) begin
            fails++;
            $display("FAIL write_cursor: (%0d,%0d), required (2,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_clear_priority();
        int cnt, nbad, first;
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        #1;
        tests++;
        if (wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_blocks_ready: wr_ready=%b, required 0", wr_ready);
        end
        @(negedge pclk);
        clear    = 1'b0;
        wr_valid = 1'b0;
        model_blank();
        wait_busy(cnt);
        tests++;
        if (cnt !== 240) begin
            fails++;
            $display("FAIL clear_len: busy cycles=%0d, required 240", cnt);
        end
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0 || cursor_x !== 5'd0 || cursor_y !== 3'd0) begin
            fails++;
            $display("FAIL clear_grid: %0d bad cells (first %0d) cursor (%0d,%0d), required 0 and (0,0)",
                     nbad, first, cursor_x, cursor_y);
        end
    endtask

    task automatic test_wrap_backspace();
        int nbad, first;
        logic [6:0] code;
        repeat (30) drive_byte(8'h41);
        wr_valid = 1'b0;
        read_cell(8'd29, code);
        tests++;
        if (cursor_x !== 5'd0 || cursor_y !== 3'd1 || code !== 7'h41) begin
            fails++;
            $display("FAIL wrap: cursor (%0d,%0d) cell29=%h, required (0,1) 41", cursor_x, cursor_y, code);
        end
        drive_byte(8'h08);
        wr_valid = 1'b0;
        read_cell(8'd29, code);
        tests++;
        if (cursor_x !== 5'd29 || cursor_y !== 3'd0 || code !== 7'h20) begin
            fails++;
            $display("FAIL backspace_row: cursor (%0d,%0d) cell29=%h, required (29,0) 20", cursor_x, cursor_y, code);
        end
        repeat (30) drive_byte(8'h08);
        wr_valid = 1'b0;
        @(negedge pclk);
        tests++;
        if (cursor_x !== 5'd0 || cursor_y !== 3'd0) begin
            fails++;
            $display("FAIL backspace_origin: cursor (%0d,%0d), required (0,0)", cursor_x, cursor_y);
        end
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0) begin
            fails++;
            $display("FAIL backspace_grid: %0d bad cells, first at %0d, required 0", nbad, first);
        end
    endtask

    task automatic test_ignored();
        int nbad, first;
        logic [7:0] codes [3];
        codes[0] = 8'h07;
        codes[1] = 8'h7F;
        codes[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = codes[i];
            #1;
            tests++;
            if (wr_ready !== 1'b1) begin
                fails++;
                $display("FAIL ignored_ready_%h: wr_ready=%b, required 1", codes[i], wr_ready);
            end
            @(negedge pclk);
        end
        wr_valid = 1'b0;
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0 || cursor_x !== 5'(mx) || cursor_y !== 3'(my)) begin
            fails++;
            $display("FAIL ignored_state: %0d bad cells cursor (%0d,%0d), required 0 (%0d,%0d)",
                     nbad, cursor_x, cursor_y, mx, my);
        end
    endtask

    task automatic test_scroll();
        int cnt, nbad, first;
        logic [6:0] c0, c6, c7;
        for (int r = 0; r < ROWS - 1; r++)
            repeat (COLS) drive_byte(8'h30 + 8'(r));
        repeat (COLS - 1) drive_byte(8'h37);
        wr_valid = 1'b0;
        @(negedge pclk);
        tests++;
        if (cursor_x !== 5'd29 || cursor_y !== 3'd7) begin
            fails++;
            $display("FAIL scroll_prefill_cursor: (%0d,%0d), required (29,7)", cursor_x, cursor_y);
        end
        drive_byte(8'h0A);
        wr_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL scroll_entry: busy=%b wr_ready=%b, required 1 0", busy, wr_ready);
        end
        wait_busy(cnt);
        tests++;
        if (cnt !== 450 || wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL scroll_len: busy cycles=%0d wr_ready=%b, required 450 1", cnt, wr_ready);
        end
        read_cell(8'h00, c0);
        read_cell({3'd6, 5'd0}, c6);
        read_cell({3'd7, 5'd0}, c7);
        tests++;
        if (c0 !== 7'h31 || c6 !== 7'h37 || c7 !== 7'h20 || cursor_x !== 5'd0 || cursor_y !== 3'd7) begin
            fails++;
            $display("FAIL scroll_rows: r0=%h r6=%h r7=%h cursor (%0d,%0d), required 31 37 20 (0,7)",
                     c0, c6, c7, cursor_x, cursor_y);
        end
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0) begin
            fails++;
            $display("FAIL scroll_grid: %0d bad cells, first at %0d, required 0", nbad, first);
        end
    endtask

    task automatic test_scroll_restart();
        int cnt, nbad, first;
        repeat (COLS) drive_byte(8'h61);
        wr_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || cursor_x !== 5'd0 || cursor_y !== 3'd7) begin
            fails++;
            $display("FAIL wrap_scroll_entry: busy=%b cursor (%0d,%0d), required 1 (0,7)", busy, cursor_x, cursor_y);
        end
        repeat (99) @(negedge pclk);
        clear = 1'b1;
        @(negedge pclk);
        clear = 1'b0;
        model_blank();
        wait_busy(cnt);
        tests++;
        if (cnt !== 240) begin
            fails++;
            $display("FAIL restart_len: busy cycles=%0d, required 240", cnt);
        end
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0 || cursor_x !== 5'd0 || cursor_y !== 3'd0) begin
            fails++;
            $display("FAIL restart_grid: %0d bad cells (first %0d) cursor (%0d,%0d), required 0 (0,0)",
                     nbad, first, cursor_x, cursor_y);
        end
    endtask

    task automatic test_random();
        int cnt, nbad, first, k;
        logic [7:0] b, xy;
        logic [6:0] code, exp;
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 99);
            if (k < 60) begin
                b = 8'($urandom_range(32, 126));
            end else if (k < 70) begin
                b = (k % 2 == 0) ? 8'h0A : 8'h0D;
            end else if (k < 85) begin
                b = 8'h08;
            end else begin
                b = 8'($urandom_range(0, 255));
                while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0D)
                    b = 8'($urandom_range(0, 255));
            end
            drive_byte(b);
        end
        wait_busy(cnt);
        tests++;
        if (cursor_x !== 5'(mx) || cursor_y !== 3'(my)) begin
            fails++;
            $display("FAIL random_cursor: (%0d,%0d), required (%0d,%0d)", cursor_x, cursor_y, mx, my);
        end
        grid_diff(nbad, first);
        tests++;
        if (nbad !== 0) begin
            fails++;
            $display("FAIL random_grid: %0d bad cells, first at %0d, required 0", nbad, first);
        end
        nbad = 0;
        for (int i = 0; i < 64; i++) begin
            xy = 8'($urandom_range(0, 255));
            exp = (int'(xy[4:0]) < COLS) ? mg[xy[7:5]][xy[4:0]][6:0] : BL[6:0];
            read_cell(xy, code);
            if (code !== exp) nbad++;
        end
        tests++;
        if (nbad !== 0) begin
            fails++;
            $display("FAIL random_lookup: %0d of 64 lookups wrong, required 0", nbad);
        end
    endtask

    initial begin
        @(negedge pclk);
        test_reset();
        test_write();
        test_clear_priority();
        test_wrap_backspace();
        test_ignored();
        test_scroll();
        test_scroll_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
